// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned PCs to the memory arbiter and
// queues the returned words for decode. Optional counters: FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic [31:0] pc_o,
    input  logic [31:0] if_rdata_i,
    input  logic        hold_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        id_ready_i,
    output logic        misalign_o,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_flushed_o
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [31:0]   pc_q;
    logic          infl_v_q;
    logic [31:0]   infl_pc_q;
    logic          misalign_q;
    logic [31:0]   fifo_pc    [BUF_DEPTH];
    logic [31:0]   fifo_instr [BUF_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occupancy;

    assign instr_valid_o = (count != '0);
    assign pop           = instr_valid_o & id_ready_i & ~redirect_i;
    assign push          = infl_v_q & ~hold_i & ~redirect_i;

    // Slots already claimed after this cycle's pop; issuing only when one is
    // left guarantees every kept response has room to land.
    always_comb begin
        occupancy = {1'b0, count} + (CW+1)'(infl_v_q) - (CW+1)'(pop);
        issue     = ~hold_i & ~redirect_i & (occupancy < (CW+1)'(BUF_DEPTH));
    end

    assign pc_o       = pc_q;
    assign misalign_o = misalign_q;
    assign instr_o    = instr_valid_o ? fifo_instr[rd_ptr] : 32'h0;
    assign instr_pc_o = instr_valid_o ? fifo_pc[rd_ptr]    : 32'h0;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pc_q       <= {RESET_PC[31:2], 2'b00};
            infl_v_q   <= 1'b0;
            infl_pc_q  <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_i & (|redirect_pc_i[1:0]);
            infl_v_q   <= issue;
            if (issue) begin
                infl_pc_q <= pc_q;
            end
            if (redirect_i) begin
                pc_q <= {redirect_pc_i[31:2], 2'b00};
            end else if (hold_i) begin
                // The in-flight response is void, so fetch that word again.
                if (infl_v_q) begin
                    pc_q <= infl_pc_q;
                end
            end else if (issue) begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= infl_pc_q;
            fifo_instr[wr_ptr] <= if_rdata_i;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q;
    logic [31:0] flushed_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            fetched_q <= 32'h0;
            flushed_q <= 32'h0;
        end else begin
            if (push) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (redirect_i) begin
                flushed_q <= flushed_q + 32'(count) + 32'(infl_v_q);
            end
        end
    end

    assign perf_fetched_o = fetched_q;
    assign perf_flushed_o = flushed_q;
`else
    assign perf_fetched_o = 32'h0;
    assign perf_flushed_o = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; memory returns 0x1000_0000|addr
// one cycle after the address is presented.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] pc_o;
    logic [31:0] if_rdata_i;
    logic        hold_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        id_ready_i;
    logic        misalign_o;
    logic [31:0] perf_fetched_o;
    logic [31:0] perf_flushed_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_q;

    fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .pc_o           (pc_o),
        .if_rdata_i     (if_rdata_i),
        .hold_i         (hold_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .instr_o        (instr_o),
        .instr_pc_o     (instr_pc_o),
        .instr_valid_o  (instr_valid_o),
        .id_ready_i     (id_ready_i),
        .misalign_o     (misalign_o),
        .perf_fetched_o (perf_fetched_o),
        .perf_flushed_o (perf_flushed_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory answers the address seen at each edge during the following cycle.
    always @(posedge clk_i) mem_q <= 32'h1000_0000 | pc_o;
    assign if_rdata_i = mem_q;

    task automatic applyStimulus(input logic rst_n, input logic ready, input logic hold,
                                 input logic redir, input logic [31:0] rpc);
        rst_n_i       = rst_n;
        id_ready_i    = ready;
        hold_i        = hold;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Head entry plus the address currently being presented to memory.
    task automatic checkStream(input string tag, input logic valid, input logic [31:0] ipc,
                               input logic [31:0] pc);
        checkOutput({tag, ".valid"}, 32'(instr_valid_o), 32'(valid));
        if (valid) begin
            checkOutput({tag, ".instr_pc"}, instr_pc_o, ipc);
            checkOutput({tag, ".instr"}, instr_o, 32'h1000_0000 | ipc);
        end
        checkOutput({tag, ".pc"}, pc_o, pc);
    endtask

    task automatic checkPerf(input string tag, input logic [31:0] fetched, input logic [31:0] flushed);
`ifdef FETCH_PERF_CNT_EN
        checkOutput({tag, ".fetched"}, perf_fetched_o, fetched);
        checkOutput({tag, ".flushed"}, perf_flushed_o, flushed);
`else
        checkOutput({tag, ".fetched"}, perf_fetched_o, 32'h0);
        checkOutput({tag, ".flushed"}, perf_flushed_o, 32'h0);
`endif
    endtask

    initial begin
        $display("[TB] start");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkStream("reset", 1'b0, 32'h0, 32'h0);
        checkOutput("reset.instr", instr_o, 32'h0);
        checkOutput("reset.instr_pc", instr_pc_o, 32'h0);
        checkOutput("reset.misalign", 32'(misalign_o), 32'h0);
        checkPerf("reset", 32'h0, 32'h0);

        // Reset release: first edge issues 0, valid data appears after the second.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkStream("first_issue", 1'b0, 32'h0, 32'h4);
        for (int k = 2; k <= 5; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            checkStream("stream", 1'b1, 32'(4 * (k - 2)), 32'(4 * k));
        end

        // Hold while 0x10 is in flight: PC rewinds, 0xC still popped.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkStream("hold", 1'b0, 32'h0, 32'h10);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkStream("hold_reissue", 1'b0, 32'h0, 32'h14);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkStream("hold_once", 1'b1, 32'h10, 32'h18);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkStream("hold_next", 1'b1, 32'h14, 32'h1C);

        // Decode stalls for five cycles: FIFO fills, PC freezes, head stays put.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            checkStream("stall", 1'b1, 32'h14, 32'h1C);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkStream("release0", 1'b1, 32'h18, 32'h20);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkStream("release1", 1'b1, 32'h1C, 32'h24);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkStream("release2", 1'b1, 32'h20, 32'h28);

        // Redirect with one queued entry and one word in flight.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
        checkStream("redirect", 1'b0, 32'h0, 32'h200);
        checkOutput("redirect.misalign", 32'(misalign_o), 32'h0);
        checkPerf("redirect", 32'd9, 32'd2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkStream("redir_issue", 1'b0, 32'h0, 32'h204);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkStream("redir_first", 1'b1, 32'h200, 32'h208);
        checkPerf("redir_first", 32'd10, 32'd2);

        // Misaligned target: aligned PC, single-cycle misalign pulse.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h203);
        checkStream("misalign", 1'b0, 32'h0, 32'h200);
        checkOutput("misalign.pulse", 32'(misalign_o), 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("misalign.drop", 32'(misalign_o), 32'h0);
        checkStream("misalign_issue", 1'b0, 32'h0, 32'h204);
        checkPerf("misalign", 32'd10, 32'd4);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkStream("misalign_first", 1'b1, 32'h200, 32'h208);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkStream("misalign_next", 1'b1, 32'h204, 32'h20C);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkStream("fill", 1'b1, 32'h204, 32'h20C);
        checkPerf("fill", 32'd13, 32'd4);

        // Reset with a full FIFO.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkStream("mid_reset", 1'b0, 32'h0, 32'h0);
        checkOutput("mid_reset.instr", instr_o, 32'h0);
        checkOutput("mid_reset.instr_pc", instr_pc_o, 32'h0);
        checkPerf("mid_reset", 32'h0, 32'h0);

        // PC wraps past the top of the address space.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        checkStream("wrap_redirect", 1'b0, 32'h0, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkStream("wrap_issue", 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkStream("wrap_data", 1'b1, 32'hFFFF_FFFC, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
